// File: rtl/gcn_pkg.sv
// -----------------------------------------------------------------------------
// gcn_pkg
// Shared definitions for the GCN result path: default problem dimensions and
// the state encoding of the result serializer FSM.
// -----------------------------------------------------------------------------
package gcn_pkg;

    // Default number of graph nodes (one class result per node).
    localparam int GCN_FEATURE_ROWS      = 6;
    // Default width of one class index (argmax address).
    localparam int GCN_MAX_ADDRESS_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        REPORT = 2'd2
    } ser_state_e;

endpackage

// File: rtl/gcn_result_serializer.sv
// -----------------------------------------------------------------------------
// gcn_result_serializer
// Snapshots the per-node argmax results of the GCN when its done level rises,
// then streams them out one node per beat over a valid/ready handshake while
// building a per-class histogram of the accepted beats.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high reset
//   done_in      in   completion level from the GCN top
//   class_in     in   argmax answer per node, [0:FEATURE_ROWS-1]
//   out_valid    out  a result beat is presented (high exactly in SEND)
//   out_ready    in   downstream accepts the beat
//   out_node     out  node index of the current beat
//   out_class    out  class of the current beat
//   out_last     out  current beat is the last node
//   class_count  out  histogram of accepted beats, one bin per class
//   report_done  out  one-cycle pulse after the last beat is accepted
//   busy         out  high in SEND and REPORT
//   overrun      out  sticky: a new result arrived while busy
// -----------------------------------------------------------------------------
module gcn_result_serializer
    import gcn_pkg::*;
#(
    parameter int FEATURE_ROWS      = GCN_FEATURE_ROWS,
    parameter int MAX_ADDRESS_WIDTH = GCN_MAX_ADDRESS_WIDTH,
    parameter int NODE_WIDTH        = $clog2(FEATURE_ROWS),
    parameter int COUNT_WIDTH       = $clog2(FEATURE_ROWS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         done_in,
    input  logic [MAX_ADDRESS_WIDTH-1:0] class_in    [0:FEATURE_ROWS-1],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NODE_WIDTH-1:0]        out_node,
    output logic [MAX_ADDRESS_WIDTH-1:0] out_class,
    output logic                         out_last,
    output logic [COUNT_WIDTH-1:0]       class_count [0:(2**MAX_ADDRESS_WIDTH)-1],
    output logic                         report_done,
    output logic                         busy,
    output logic                         overrun
);

    localparam int NUM_CLASSES = 2**MAX_ADDRESS_WIDTH;
    localparam logic [NODE_WIDTH-1:0] LAST_NODE = NODE_WIDTH'(FEATURE_ROWS - 1);

    ser_state_e                   state_q, state_d;
    logic                         done_q, done_d;
    logic [NODE_WIDTH-1:0]        index_q, index_d;
    logic [MAX_ADDRESS_WIDTH-1:0] snap_q  [0:FEATURE_ROWS-1];
    logic [MAX_ADDRESS_WIDTH-1:0] snap_d  [0:FEATURE_ROWS-1];
    logic [COUNT_WIDTH-1:0]       count_q [0:NUM_CLASSES-1];
    logic [COUNT_WIDTH-1:0]       count_d [0:NUM_CLASSES-1];
    logic                         overrun_q, overrun_d;

    logic rise;
    logic xfer;

    // A held-high done level never retriggers: only a 0->1 transition counts.
    assign rise = done_in & ~done_q;
    assign xfer = (state_q == SEND) & out_ready;

    always_comb begin
        state_d   = state_q;
        done_d    = done_in;
        index_d   = index_q;
        snap_d    = snap_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    snap_d  = class_in;
                    index_d = '0;
                    for (int c = 0; c < NUM_CLASSES; c++) begin
                        count_d[c] = '0;
                    end
                    state_d = SEND;
                end
            end
            SEND: begin
                // A new result while streaming is dropped; the snapshot is kept.
                if (rise) begin
                    overrun_d = 1'b1;
                end
                if (xfer) begin
                    count_d[snap_q[index_q]] = count_q[snap_q[index_q]] + COUNT_WIDTH'(1);
                    if (index_q == LAST_NODE) begin
                        state_d = REPORT;
                    end else begin
                        index_d = index_q + NODE_WIDTH'(1);
                    end
                end
            end
            REPORT: begin
                if (rise) begin
                    overrun_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            index_q   <= '0;
            overrun_q <= 1'b0;
            for (int n = 0; n < FEATURE_ROWS; n++) begin
                snap_q[n] <= '0;
            end
            for (int c = 0; c < NUM_CLASSES; c++) begin
                count_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            index_q   <= index_d;
            overrun_q <= overrun_d;
            snap_q    <= snap_d;
            count_q   <= count_d;
        end
    end

    // All beat outputs decode straight from flops, so they hold while stalled.
    assign out_valid   = (state_q == SEND);
    assign out_node    = index_q;
    assign out_class   = snap_q[index_q];
    assign out_last    = (state_q == SEND) && (index_q == LAST_NODE);
    assign report_done = (state_q == REPORT);
    assign busy        = (state_q == SEND) || (state_q == REPORT);
    assign overrun     = overrun_q;
    assign class_count = count_q;

endmodule

// File: tb/tb_gcn_result_serializer.sv
module tb_gcn_result_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       done_in;
    logic [1:0] class_in [0:5];
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_node;
    logic [1:0] out_class;
    logic       out_last;
    logic [2:0] class_count [0:3];
    logic       report_done;
    logic       busy;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    gcn_result_serializer dut (
        .clk         (clk),
        .reset       (reset),
        .done_in     (done_in),
        .class_in    (class_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_node    (out_node),
        .out_class   (out_class),
        .out_last    (out_last),
        .class_count (class_count),
        .report_done (report_done),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_counts(input string tag, input int c0, input int c1, input int c2, input int c3);
        chk({tag, "_cnt0"}, 32'(class_count[0]), c0);
        chk({tag, "_cnt1"}, 32'(class_count[1]), c1);
        chk({tag, "_cnt2"}, 32'(class_count[2]), c2);
        chk({tag, "_cnt3"}, 32'(class_count[3]), c3);
    endtask

    task automatic chk_beat(input string tag, input int node, input int cls, input bit last);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_node"},  32'(out_node),  node);
        chk({tag, "_class"}, 32'(out_class), cls);
        chk({tag, "_last"},  32'(out_last),  32'(last));
    endtask

    // Hand-derived data for the main job: classes 0,1,2,3,1,0.
    int data1 [0:5] = '{0, 1, 2, 3, 1, 0};
    int pat   [0:2] = '{1, 0, 0};

    initial begin
        int exp_node;
        int cyc;

        reset    = 1'b1;
        done_in  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) class_in[i] = 2'd0;
        #2;
        // ---------------- reset state
        chk("rst_valid",  32'(out_valid),   0);
        chk("rst_node",   32'(out_node),    0);
        chk("rst_class",  32'(out_class),   0);
        chk("rst_last",   32'(out_last),    0);
        chk("rst_rdone",  32'(report_done), 0);
        chk("rst_busy",   32'(busy),        0);
        chk("rst_ovr",    32'(overrun),     0);
        chk_counts("rst", 0, 0, 0, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) class_in[i] = 2'(data1[i]);
        out_ready = 1'b1;
        step();
        chk("idle_valid", 32'(out_valid), 0);

        // ---------------- job 1: ready always high
        done_in = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            chk_beat($sformatf("j1_b%0d", i), i, data1[i], i == 5);
            chk($sformatf("j1_b%0d_busy", i), 32'(busy), 1);
            step();
        end
        chk("j1_rdone", 32'(report_done), 1);
        chk("j1_rvalid", 32'(out_valid), 0);
        chk("j1_rbusy", 32'(busy), 1);
        step();
        chk("j1_rdone_end", 32'(report_done), 0);
        chk("j1_idle_busy", 32'(busy), 0);
        chk_counts("j1", 2, 2, 1, 1);

        // ---------------- job 2: ready pattern 1,0,0 repeating
        done_in = 1'b0;
        step();
        chk("j2_hold_valid", 32'(out_valid), 0);
        done_in = 1'b1;
        step();
        exp_node = 0;
        cyc = 0;
        while (exp_node < 6 && cyc < 40) begin
            chk_beat($sformatf("j2_c%0d", cyc), exp_node, data1[exp_node], exp_node == 5);
            out_ready = pat[cyc % 3][0];
            step();
            if (pat[cyc % 3] == 1) exp_node++;
            cyc++;
        end
        chk("j2_finished_in_budget", 32'(exp_node), 6);
        out_ready = 1'b1;
        chk("j2_rdone", 32'(report_done), 1);
        step();
        chk_counts("j2", 2, 2, 1, 1);
        chk("j2_ovr", 32'(overrun), 0);

        // ---------------- job 3: second rise during node 2
        done_in = 1'b0;
        step();
        done_in = 1'b1;
        step();
        chk_beat("j3_b0", 0, 0, 0);
        step();
        step();
        chk_beat("j3_b2", 2, 2, 0);
        out_ready = 1'b0;
        done_in = 1'b0;
        class_in[2] = 2'd1;
        step();
        done_in = 1'b1;
        step();
        chk("j3_ovr", 32'(overrun), 1);
        chk_beat("j3_b2_stall", 2, 2, 0);
        out_ready = 1'b1;
        for (int i = 2; i < 6; i++) begin
            chk_beat($sformatf("j3_b%0d", i), i, data1[i], i == 5);
            step();
        end
        chk("j3_rdone", 32'(report_done), 1);
        step();
        // done_in still high across report_done: no new job
        step();
        step();
        chk("j3_no_retrig", 32'(out_valid), 0);
        chk("j3_ovr_sticky", 32'(overrun), 1);
        chk_counts("j3", 2, 2, 1, 1);

        // ---------------- job 4: all class 3, inputs change after capture
        done_in = 1'b0;
        for (int i = 0; i < 6; i++) class_in[i] = 2'd3;
        step();
        done_in = 1'b1;
        step();
        for (int i = 0; i < 6; i++) class_in[i] = 2'd0;
        for (int i = 0; i < 6; i++) begin
            chk_beat($sformatf("j4_b%0d", i), i, 3, i == 5);
            step();
        end
        chk("j4_rdone", 32'(report_done), 1);
        step();
        chk_counts("j4", 0, 0, 0, 6);

        // ---------------- job 5: reset mid-SEND at node 3
        done_in = 1'b0;
        for (int i = 0; i < 6; i++) class_in[i] = 2'(data1[i]);
        step();
        done_in = 1'b1;
        step();
        step();
        step();
        step();
        chk_beat("j5_b3", 3, 3, 0);
        reset = 1'b1;
        #1;
        chk("j5_rst_valid", 32'(out_valid), 0);
        chk("j5_rst_ovr",   32'(overrun),   0);
        chk("j5_rst_busy",  32'(busy),      0);
        chk_counts("j5_rst", 0, 0, 0, 0);
        step();
        chk("j5_rst_hold_valid", 32'(out_valid), 0);
        reset = 1'b0;
        step();
        chk_beat("j5_restart_b0", 0, 0, 0);
        chk_counts("j5_restart", 0, 0, 0, 0);
        step();
        chk_beat("j5_restart_b1", 1, 1, 0);
        chk_counts("j5_restart_b1", 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gcn_result_serializer.md
GCN_RESULT_SERIALIZER -- requirements
Module: gcn_result_serializer

Interface
REQ-001 Parameter FEATURE_ROWS, default 6: number of graph nodes, one class result per node.
REQ-002 Parameter MAX_ADDRESS_WIDTH, default 2: width of one class index.
REQ-003 Parameter NODE_WIDTH, default $clog2(FEATURE_ROWS): width of the node index.
REQ-004 Parameter COUNT_WIDTH, default $clog2(FEATURE_ROWS+1): width of one histogram bin.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 done_in  input  1  completion level from the GCN top (its done output).
REQ-008 class_in  input  MAX_ADDRESS_WIDTH x [0:FEATURE_ROWS-1]  argmax answers (max_addi_answer).
REQ-009 out_valid  output  1  a result beat is presented.
REQ-010 out_ready  input  1  downstream accepts the beat.
REQ-011 out_node  output  NODE_WIDTH  node index of the current beat.
REQ-012 out_class  output  MAX_ADDRESS_WIDTH  class of the current beat.
REQ-013 out_last  output  1  current beat is node FEATURE_ROWS-1.
REQ-014 class_count  output  COUNT_WIDTH x [0:2**MAX_ADDRESS_WIDTH-1]  per-class histogram of accepted beats.
REQ-015 report_done  output  1  one-cycle pulse after the last beat is accepted.
REQ-016 busy  output  1  high in SEND and REPORT.
REQ-017 overrun  output  1  sticky: a new result arrived while busy.

Function
REQ-018 The block SHALL register done_in into done_q each cycle and define rise = done_in AND NOT done_q.
REQ-019 FSM states SHALL be IDLE, SEND, REPORT.
REQ-020 IDLE + rise: capture all class_in into snapshot buffer, clear class_count to 0, set node index to 0, go to SEND on the same edge.
REQ-021 out_valid SHALL be high exactly while in SEND; first beat is visible the cycle after the rise edge (latency 1).
REQ-022 In SEND, out_node = index, out_class = snapshot[index], out_last = (index == FEATURE_ROWS-1); all registered or driven from registers only.
REQ-023 out_node/out_class/out_last SHALL stay stable while out_valid AND NOT out_ready.
REQ-024 Transfer = out_valid AND out_ready; on transfer, class_count[out_class] increments by 1 (no saturation needed; max value FEATURE_ROWS fits COUNT_WIDTH).
REQ-025 Transfer with index < FEATURE_ROWS-1: index increments, stay in SEND.
REQ-026 Transfer with index = FEATURE_ROWS-1: go to REPORT; report_done high for the single REPORT cycle; then IDLE.
REQ-027 class_count SHALL hold its final values in IDLE until the next capture.
REQ-028 rise while in SEND or REPORT SHALL be ignored (snapshot unchanged) and SHALL set overrun.
REQ-029 done_in held high SHALL NOT retrigger; a new job requires done_in to fall and rise again.
REQ-030 out_ready high outside SEND SHALL have no effect; out_ready permanently high gives FEATURE_ROWS beats on consecutive cycles.
REQ-031 class_in changes after capture SHALL NOT affect emitted beats.

Reset
REQ-032 reset SHALL force, asynchronously: state IDLE, done_q 0, index 0, snapshot 0, class_count all 0, out_valid 0, out_last 0, out_node 0, out_class 0, report_done 0, busy 0, overrun 0.
REQ-033 reset mid-SEND SHALL abort the job with no further beats; after release, done_in already high SHALL count as rise only if done_q was cleared (i.e. it triggers a capture on the first edge).

Structure
REQ-034 FSM state enum (IDLE, SEND, REPORT) and default FEATURE_ROWS/MAX_ADDRESS_WIDTH constants SHALL live in shared package gcn_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; the histogram is in-line logic.

Verification
REQ-036 Reset, class_in={0,1,2,3,1,0}, done_in rises, out_ready=1 -> beats node0..5 classes 0,1,2,3,1,0 on 6 consecutive cycles starting 1 cycle after rise, out_last on node5, report_done next cycle, class_count={2,2,1,1}.
REQ-037 Same data, out_ready toggled 1,0,0,1,... -> beats stable while stalled, order and counts identical to REQ-036.
REQ-038 done_in rises, then falls and rises again during node2 -> overrun=1, beats unchanged, no second job until next rise in IDLE.
REQ-039 done_in held high across report_done -> no second job; drop and re-raise with class_in all 3 -> 6 beats of class 3, class_count={0,0,0,6}.
REQ-040 reset asserted mid-SEND at node3 -> out_valid 0 immediately, class_count 0, overrun 0; with done_in high at release, new job starts at node0.
